mult_sequencer: RTL
===================

MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have ports req_valid (input, 1), req_ready (output, 1), req_a (input, 32), req_b (input, 32) and req_tag (input, 4), forming the operand request channel.
REQ-004 SHALL have ports core_execute (output, 1), core_a (output, 32), core_b (output, 32), core_ready (input, 1, one-cycle done pulse) and core_product (input, 64), forming the multiplier-core channel.
REQ-005 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_product (output, 64), rsp_tag (output, 4) and rsp_error (output, 1), forming the response channel.
REQ-006 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-007 SHALL have parameter TIMEOUT, default 100: the maximum number of WAIT cycles.
REQ-008 SHALL have parameter DRAIN_CYC, default 72: the post-reset drain length, greater than the core latency of 66.

Function
REQ-009 SHALL implement states DRAIN, IDLE, ISSUE, WAIT and RESP, plus a 7-bit cycle counter.
REQ-010 SHALL hold a one-entry pending buffer (a, b, tag, pend_valid); req_ready = !pend_valid && !Reset.
REQ-011 SHALL load the pending buffer and set pend_valid on any cycle where req_valid && req_ready, in any state, including DRAIN.
REQ-012 SHALL count DRAIN cycles in the counter and move to IDLE when the counter reaches DRAIN_CYC-1; core_ready is ignored in DRAIN.
REQ-013 SHALL go from IDLE to ISSUE when pend_valid=1, copying pending into the active registers (core_a, core_b, active tag) and clearing pend_valid on that edge.
REQ-014 SHALL assert core_execute=1 for exactly the one ISSUE cycle, then go to WAIT with the counter cleared.
REQ-015 SHALL hold core_a and core_b stable from ISSUE through the end of WAIT.
REQ-016 SHALL, in WAIT with core_ready=1, capture core_product into rsp_product, set rsp_error=0 and go to RESP.
REQ-017 SHALL, in WAIT, increment the counter each cycle; at counter==TIMEOUT-1 with core_ready=0, set rsp_product=0 and rsp_error=1 and go to RESP.
REQ-018 SHALL give core_ready priority when core_ready and timeout occur in the same cycle (normal capture, no error).
REQ-019 SHALL, in RESP, hold rsp_valid=1 with rsp_product, rsp_tag and rsp_error unchanged until rsp_ready=1.
REQ-020 SHALL, on the RESP handshake, go to ISSUE if pend_valid=1 (with the pending copy per REQ-013), otherwise to IDLE.
REQ-021 SHALL ignore core_ready in IDLE, ISSUE and RESP, with no capture and no state change.
REQ-022 SHALL set rsp_valid=1 only in RESP; rsp_tag equals the tag of the issued request.
REQ-023 SHALL give request-to-core latency as follows: accept at edge N gives core_execute high in the cycle after edge N+1, when issued from IDLE.

Reset
REQ-024 SHALL, on Reset=1 at a rising edge, set state=DRAIN, counter=0, pend_valid=0, core_execute=0, rsp_valid=0, rsp_error=0, rsp_product=0, rsp_tag=0, core_a=0 and core_b=0.
REQ-025 SHALL discard any in-flight request when Reset is asserted mid-operation (ISSUE, WAIT or RESP), produce no response for it, and run DRAIN so that a stale core_ready cannot be captured.
REQ-026 SHALL drive busy=1 and req_ready=0 while Reset=1.

Verification
REQ-027 SHALL cover a single request: after drain, a=3, b=5, tag=2; core model pulses core_ready 66 cycles after core_execute with product 15 -> one core_execute pulse; rsp_valid, rsp_product=15, rsp_tag=2, rsp_error=0.
REQ-028 SHALL cover back-to-back requests: tag 1 accepted; tag 2 accepted during WAIT; tag 3 -> req_ready=0 until tag 2 issues; responses appear in order 1, 2, then 3.
REQ-029 SHALL cover response backpressure: rsp_ready=0 for 10 cycles with a pending request -> response fields stable, no core_execute; rsp_ready=1 -> ISSUE on the next cycle.
REQ-030 SHALL cover timeout: core model never responds -> RESP after 100 WAIT cycles with rsp_error=1, rsp_product=0, tag preserved.
REQ-031 SHALL cover reset mid-WAIT: Reset pulsed at WAIT cycle 20 -> outputs cleared, core_ready at cycle 66 ignored, 72-cycle DRAIN, no response for the old request.
REQ-032 SHALL cover a stray core_ready in IDLE with product 0xDEAD -> no rsp_valid, and rsp_product unchanged.

Source files
------------

// File: rtl/mult_sequencer.sv
// Issues one operand pair at a time to an external multi-cycle multiplier core.
// Provides a one-entry request buffer, a WAIT timeout, and a post-reset drain.
module mult_sequencer #(
  parameter int TIMEOUT   = 100,
  parameter int DRAIN_CYC = 72
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [3:0]  req_tag,
  output logic        core_execute,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  input  logic        core_ready,
  input  logic [63:0] core_product,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_product,
  output logic [3:0]  rsp_tag,
  output logic        rsp_error,
  output logic        busy
);

  typedef enum logic [2:0] {S_DRAIN, S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [6:0] DRAIN_LAST   = 7'(DRAIN_CYC - 1);
  localparam logic [6:0] TIMEOUT_LAST = 7'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_a_q, pend_a_d;
  logic [31:0] pend_b_q, pend_b_d;
  logic [3:0]  pend_tag_q, pend_tag_d;
  logic [31:0] act_a_q, act_a_d;
  logic [31:0] act_b_q, act_b_d;
  logic [3:0]  act_tag_q, act_tag_d;
  logic [63:0] prod_q, prod_d;
  logic        err_q, err_d;
  logic        accept;
  logic        take_pend;

  assign req_ready    = !pend_vld_q && !Reset;
  assign accept       = req_valid && req_ready;
  assign core_execute = (state_q == S_ISSUE);
  assign rsp_valid    = (state_q == S_RESP);
  assign busy         = (state_q != S_IDLE) || Reset;
  assign core_a       = act_a_q;
  assign core_b       = act_b_q;
  assign rsp_product  = prod_q;
  assign rsp_tag      = act_tag_q;
  assign rsp_error    = err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_vld_d = pend_vld_q;
    pend_a_d   = pend_a_q;
    pend_b_d   = pend_b_q;
    pend_tag_d = pend_tag_q;
    act_a_d    = act_a_q;
    act_b_d    = act_b_q;
    act_tag_d  = act_tag_q;
    prod_d     = prod_q;
    err_d      = err_q;
    take_pend  = 1'b0;

    // The buffer accepts in every state, including DRAIN.
    if (accept) begin
      pend_vld_d = 1'b1;
      pend_a_d   = req_a;
      pend_b_d   = req_b;
      pend_tag_d = req_tag;
    end

    case (state_q)
      S_DRAIN: begin
        // core_ready is deliberately ignored so a stale pulse from a core that
        // was mid-operation at reset cannot be mistaken for a new result.
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_IDLE: begin
        if (pend_vld_q) begin
          state_d   = S_ISSUE;
          take_pend = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (core_ready) begin
          prod_d  = core_product;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == TIMEOUT_LAST) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          if (pend_vld_q) begin
            state_d   = S_ISSUE;
            take_pend = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_DRAIN;
    endcase

    if (take_pend) begin
      act_a_d    = pend_a_q;
      act_b_d    = pend_b_q;
      act_tag_d  = pend_tag_q;
      pend_vld_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_DRAIN;
      cnt_q      <= '0;
      pend_vld_q <= 1'b0;
      act_a_q    <= '0;
      act_b_q    <= '0;
      act_tag_q  <= '0;
      prod_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_vld_q <= pend_vld_d;
      act_a_q    <= act_a_d;
      act_b_q    <= act_b_d;
      act_tag_q  <= act_tag_d;
      prod_q     <= prod_d;
      err_q      <= err_d;
    end
  end

  // Pending payload is only meaningful while pend_vld_q is set.
  always_ff @(posedge Clk) begin
    pend_a_q   <= pend_a_d;
    pend_b_q   <= pend_b_d;
    pend_tag_q <= pend_tag_d;
  end

endmodule
